// File: rtl/hue_pwm_gen.sv
// hue_pwm_gen: colour-wheel / breathe PWM generator for a single RGB LED.
// A free-running PWM counter defines periods; every register that shapes the
// visible colour changes only at a period boundary, so no period is ever cut.
module hue_pwm_gen #(
    parameter int PWM_INTERVAL = 1200,
    parameter int SEG_STEPS    = 100,
    parameter int STEP_DIV     = 10,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic [2:0] seg,
    output logic       period_tick
);

    localparam int DUTY_INC = PWM_INTERVAL / SEG_STEPS;
    localparam int CNT_W    = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;
    localparam int DUTY_W   = $clog2(PWM_INTERVAL + 1);
    localparam int STEP_W   = $clog2(SEG_STEPS);
    localparam int DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

    // Reject parameter sets that would make the ramp non-integral or degenerate.
    generate
        if (SEG_STEPS < 2 || STEP_DIV < 1 || (PWM_INTERVAL % SEG_STEPS) != 0) begin : g_bad_params
            $error("hue_pwm_gen: need SEG_STEPS>=2, STEP_DIV>=1, PWM_INTERVAL divisible by SEG_STEPS");
        end
    endgenerate

    logic [CNT_W-1:0]            r_pwm_cnt;
    logic [1:0]                  r_mode_q;
    logic [DIV_W-1:0]            r_div_cnt;
    logic [STEP_W-1:0]           r_step_cnt;
    logic [2:0]                  r_seg;
    logic [2:0][DUTY_W-1:0]      r_duty_q;
    logic [2:0]                  r_rgb;

    logic                        w_tick;
    logic                        w_adv;
    logic                        w_div_wrap;
    logic                        w_step_wrap;
    logic [DIV_W-1:0]            w_div_next;
    logic [STEP_W-1:0]           w_step_next;
    logic [2:0]                  w_seg_next;
    logic [DUTY_W-1:0]           w_up;
    logic [DUTY_W-1:0]           w_dn;
    logic [DUTY_W-1:0]           w_full;
    logic [DUTY_W-1:0]           w_pwm_ext;
    logic [2:0][DUTY_W-1:0]      w_duty_next;
    logic [2:0]                  w_on;

    assign w_tick      = (r_pwm_cnt == CNT_W'(PWM_INTERVAL - 1));
    // The wheel only moves in the running modes (00 hue, 01 breathe).
    assign w_adv       = w_tick && (r_mode_q == 2'b00 || r_mode_q == 2'b01);
    assign w_div_wrap  = (r_div_cnt == DIV_W'(STEP_DIV - 1));
    assign w_step_wrap = (r_step_cnt == STEP_W'(SEG_STEPS - 1));
    assign w_pwm_ext   = DUTY_W'(r_pwm_cnt);

    // Next wheel position: divider -> step -> segment cascade.
    always_comb begin
        w_div_next  = r_div_cnt;
        w_step_next = r_step_cnt;
        w_seg_next  = r_seg;
        if (w_adv) begin
            if (w_div_wrap) begin
                w_div_next = '0;
                if (w_step_wrap) begin
                    w_step_next = '0;
                    w_seg_next  = (r_seg == 3'd5) ? 3'd0 : r_seg + 3'd1;
                end else begin
                    w_step_next = r_step_cnt + STEP_W'(1);
                end
            end else begin
                w_div_next = r_div_cnt + DIV_W'(1);
            end
        end
    end

    // Ramp from the post-update step so the loaded duty matches the new position.
    assign w_full = DUTY_W'(PWM_INTERVAL);
    assign w_up   = DUTY_W'(w_step_next) * DUTY_W'(DUTY_INC);
    assign w_dn   = w_full - w_up;

    // Duty selection for the period that starts after this boundary (index 0=R,1=G,2=B).
    always_comb begin
        w_duty_next = '0;
        case (mode)
            2'b01: begin
                w_duty_next[0] = w_seg_next[0] ? w_dn : w_up;
                w_duty_next[1] = w_seg_next[0] ? w_dn : w_up;
                w_duty_next[2] = w_seg_next[0] ? w_dn : w_up;
            end
            2'b11: w_duty_next = '0;
            default: begin
                case (w_seg_next)
                    3'd0: begin w_duty_next[0] = w_full; w_duty_next[1] = w_up;   w_duty_next[2] = '0;     end
                    3'd1: begin w_duty_next[0] = w_dn;   w_duty_next[1] = w_full; w_duty_next[2] = '0;     end
                    3'd2: begin w_duty_next[0] = '0;     w_duty_next[1] = w_full; w_duty_next[2] = w_up;   end
                    3'd3: begin w_duty_next[0] = '0;     w_duty_next[1] = w_dn;   w_duty_next[2] = w_full; end
                    3'd4: begin w_duty_next[0] = w_up;   w_duty_next[1] = '0;     w_duty_next[2] = w_full; end
                    3'd5: begin w_duty_next[0] = w_full; w_duty_next[1] = '0;     w_duty_next[2] = w_dn;   end
                    default: w_duty_next = '0;
                endcase
            end
        endcase
    end

    // Counters, latched mode and duties; mode and duties change only at a boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_cnt  <= '0;
            r_mode_q   <= 2'b11;
            r_div_cnt  <= '0;
            r_step_cnt <= '0;
            r_seg      <= '0;
            r_duty_q   <= '0;
        end else begin
            r_pwm_cnt  <= w_tick ? '0 : r_pwm_cnt + CNT_W'(1);
            r_div_cnt  <= w_div_next;
            r_step_cnt <= w_step_next;
            r_seg      <= w_seg_next;
            if (w_tick) begin
                r_mode_q <= mode;
                r_duty_q <= w_duty_next;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            // Strict less-than: duty 0 never lights, duty PWM_INTERVAL never goes dark.
            assign w_on[gi] = (w_pwm_ext < r_duty_q[gi]);

            // Registered pin drive with polarity applied; reset leaves the LED dark.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rgb[gi] <= ACTIVE_LOW;
                end else begin
                    r_rgb[gi] <= w_on[gi] ^ ACTIVE_LOW;
                end
            end
        end
    endgenerate

    assign RGB_R       = r_rgb[0];
    assign RGB_G       = r_rgb[1];
    assign RGB_B       = r_rgb[2];
    assign seg         = r_seg;
    assign period_tick = w_tick;

endmodule

// File: tb/tb_hue_pwm_gen.sv
// tb_hue_pwm_gen: directed period-window checks plus randomized mode/reset
// traffic, compared every cycle against a position-based behavioural model.
module tb_hue_pwm_gen;

    localparam int P  = 8;
    localparam int SS = 4;
    localparam int SD = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] mode = 2'b11;
    logic       RGB_R, RGB_G, RGB_B;
    logic [2:0] seg;
    logic       period_tick;

    int vectors = 0;
    int miscompares = 0;
    int nprint = 0;
    bit chk_en = 1'b0;

    hue_pwm_gen #(
        .PWM_INTERVAL(P),
        .SEG_STEPS(SS),
        .STEP_DIV(SD),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mode(mode),
        .RGB_R(RGB_R),
        .RGB_G(RGB_G),
        .RGB_B(RGB_B),
        .seg(seg),
        .period_tick(period_tick)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Wheel state is a single count of advancing boundaries (m_pos);
    // segment and step are derived from it arithmetically.
    // Selector codes: 0 zero, 1 up, 2 dn, 3 full; rows = seg, columns = R,G,B.
    int tbl [6][3] = '{'{3, 1, 0}, '{2, 3, 0}, '{0, 3, 1},
                       '{0, 2, 3}, '{1, 0, 3}, '{3, 0, 2}};

    int         m_cnt;
    int         m_pos;
    logic [1:0] m_mode_q;
    int         m_duty [3];
    logic [2:0] m_rgb;

    function automatic int duty_of(input int pos, input logic [1:0] md, input int ch);
        int step, sg, up, dn, sel;
        step = (pos / SD) % SS;
        sg   = (pos / (SD * SS)) % 6;
        up   = step * (P / SS);
        dn   = P - up;
        if (md == 2'b11) return 0;
        if (md == 2'b01) return (sg % 2 == 0) ? up : dn;
        sel = tbl[sg][ch];
        case (sel)
            0: return 0;
            1: return up;
            2: return dn;
            default: return P;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    <= 0;
            m_pos    <= 0;
            m_mode_q <= 2'b11;
            for (int c = 0; c < 3; c++) m_duty[c] <= 0;
            m_rgb    <= 3'b111;
        end else begin
            for (int c = 0; c < 3; c++) m_rgb[c] <= (m_cnt < m_duty[c]) ? 1'b0 : 1'b1;
            m_cnt <= (m_cnt + 1) % P;
            if (m_cnt == P - 1) begin
                m_mode_q <= mode;
                for (int c = 0; c < 3; c++)
                    m_duty[c] <= duty_of(m_pos + ((m_mode_q inside {2'b00, 2'b01}) ? 1 : 0), mode, c);
                m_pos <= m_pos + ((m_mode_q inside {2'b00, 2'b01}) ? 1 : 0);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [2:0] eseg;
            logic       etick;
            eseg  = 3'((m_pos / (SD * SS)) % 6);
            etick = (m_cnt == P - 1);
            vectors++;
            if (RGB_R !== m_rgb[0] || RGB_G !== m_rgb[1] || RGB_B !== m_rgb[2] ||
                seg !== eseg || period_tick !== etick) begin
                miscompares++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL cycle_model t=%0t got rgb=%b%b%b seg=%0d tick=%b, expected rgb=%b%b%b seg=%0d tick=%b",
                             $time, RGB_R, RGB_G, RGB_B, seg, period_tick,
                             m_rgb[0], m_rgb[1], m_rgb[2], eseg, etick);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end else begin
            $display("ok   %s = %0d", nm, act);
        end
    endtask

    task automatic do_reset(input logic [1:0] m);
        @(negedge clk);
        mode = m;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rgb", int'({RGB_R, RGB_G, RGB_B}), 7);
        chk("reset_seg", int'(seg), 0);
        rst_n = 1'b1;
    endtask

    // Sample n negedges, counting LED-on (low) clocks and ticks; optional mode change.
    task automatic window(input int n, input int chg_at, input logic [1:0] chg_mode,
                          output int lr, output int lg, output int lb, output int nt, output int tp);
        lr = 0; lg = 0; lb = 0; nt = 0; tp = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (RGB_R == 1'b0) lr++;
            if (RGB_G == 1'b0) lg++;
            if (RGB_B == 1'b0) lb++;
            if (period_tick == 1'b1) begin nt++; tp = i; end
            if (i == chg_at) mode = chg_mode;
        end
    endtask

    task automatic period(input string nm, input int er, input int eg, input int eb,
                          input int chg_at, input logic [1:0] chg_mode);
        int lr, lg, lb, nt, tp;
        window(P, chg_at, chg_mode, lr, lg, lb, nt, tp);
        if (er >= 0) chk({nm, "_R_low"}, lr, er);
        if (eg >= 0) chk({nm, "_G_low"}, lg, eg);
        if (eb >= 0) chk({nm, "_B_low"}, lb, eb);
        chk({nm, "_ticks"}, nt, 1);
        chk({nm, "_tickpos"}, tp, P - 1);
    endtask

    task automatic wait_seg_change(output int n, output logic ok);
        logic [2:0] s0;
        s0 = seg; n = 0; ok = 1'b0;
        while (n < 300 && !ok) begin
            @(negedge clk);
            n++;
            if (seg !== s0) ok = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int g_seq [5] = '{0, 0, 2, 2, 4};
        int br_seq [16] = '{0, 0, 2, 2, 4, 4, 6, 6, 8, 8, 6, 6, 4, 4, 2, 2};
        int n;
        logic ok;

        // Hue mode from reset: dark first period, then seg0 ramp on G.
        do_reset(2'b00);
        period("hue_first", 0, 0, 0, 0, 2'b00);
        for (int k = 0; k < 5; k++) period($sformatf("hue_p%0d", k), P, g_seq[k], 0, 0, 2'b00);
        wait_seg_change(n, ok);
        chk("seg_first_value", int'(seg), 1);
        for (int k = 0; k < 6; k++) begin
            wait_seg_change(n, ok);
            chk($sformatf("seg_interval_%0d", k), n, SD * SS * P);
            chk($sformatf("seg_value_%0d", k), int'(seg), (2 + k) % 6);
        end

        // Breathe mode: all channels identical ramp up in seg0, down in seg1.
        do_reset(2'b01);
        period("br_first", 0, 0, 0, 0, 2'b01);
        for (int k = 0; k < 16; k++)
            period($sformatf("br_p%0d", k), br_seq[k], br_seq[k], br_seq[k], 0, 2'b01);

        // Hold: change mid-period, frozen for 10 periods, resume without a jump.
        do_reset(2'b00);
        period("hold_first", 0, 0, 0, 0, 2'b00);
        for (int k = 0; k < 5; k++) period($sformatf("hold_pre%0d", k), P, g_seq[k], 0, 0, 2'b00);
        period("hold_chg", P, 4, 0, 4, 2'b10);
        for (int k = 0; k < 10; k++) begin
            period($sformatf("hold_p%0d", k), P, 6, 0, (k == 9) ? 4 : 0, 2'b00);
            chk($sformatf("hold_seg%0d", k), int'(seg), 0);
        end
        period("resume_p0", P, 6, 0, 0, 2'b00);
        period("resume_p1", P, 6, 0, 0, 2'b00);
        period("resume_p2", P, P, 0, 0, 2'b00);

        // Off mode and mid-period reset.
        do_reset(2'b00);
        period("off_first", 0, 0, 0, 0, 2'b00);
        for (int k = 0; k < 10; k++) period($sformatf("off_pre%0d", k), -1, -1, -1, 0, 2'b00);
        period("off_chg", -1, -1, -1, 3, 2'b11);
        period("off_p0", 0, 0, 0, 0, 2'b11);
        period("off_p1", 0, 0, 0, 0, 2'b11);
        chk("off_seg_frozen", int'(seg), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_rgb", int'({RGB_R, RGB_G, RGB_B}), 7);
        chk("midreset_seg", int'(seg), 0);
        chk("midreset_tick", int'(period_tick), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized modes and occasional asynchronous resets.
        for (int k = 0; k < 60; k++) begin
            mode = 2'($urandom_range(0, 3));
            repeat ($urandom_range(1, 120)) @(negedge clk);
            if ($urandom_range(0, 9) == 0) begin
                #($urandom_range(1, 4));
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
